gate_exerciser: RTL and testbench

GATE_EXERCISER -- requirements
Module: gate_exerciser

---
 rtl/gate_exerciser_pkg.sv | 11 +
 rtl/gate_exerciser_ref.sv | 10 +
 rtl/gate_exerciser.sv | 144 ++++++++++++++
 tb/tb_gate_exerciser.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/gate_exerciser_pkg.sv
// Shared types and golden response for the 2-input NAND/NOR gate exerciser.
package gate_exerciser_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, DONE = 2'd2} state_e;

  localparam int NVEC = 4;

  // y[1] = NOR, y[0] = NAND
  function automatic logic [1:0] exp_y(input logic a, input logic b);
    return {~(a | b), ~(a & b)};
  endfunction
endpackage

// File: rtl/gate_exerciser_ref.sv
// Combinational golden NAND/NOR model producing the expected gate response.
import gate_exerciser_pkg::*;

module gate_ref_model (
  input  logic       a,
  input  logic       b,
  output logic [1:0] y_exp
);
  assign y_exp = exp_y(a, b);
endmodule

// File: rtl/gate_exerciser.sv
// Steps {a,b} through 00,01,10,11 (HOLD cycles each), checks y against the golden gate.
// Optional first-failure capture: define GATE_EXERCISER_FAIL_CAPTURE_EN.
import gate_exerciser_pkg::*;

module gate_exerciser #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] fail_vec,
  output logic [1:0] fail_y
);
  localparam logic [7:0] HOLD_M1  = 8'(HOLD - 1);
  localparam logic [1:0] LAST_VEC = 2'(NVEC - 1);

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] vec_q, vec_d;
  logic [2:0] err_q, err_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic [1:0] y_exp;
  logic       last, mism;

  gate_ref_model u_ref (
    .a    (vec_q[1]),
    .b    (vec_q[0]),
    .y_exp(y_exp)
  );

  assign last = (hold_q == HOLD_M1);
  assign mism = (y != y_exp);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    vec_d   = vec_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      DRIVE: begin
        if (last) begin
          hold_d = '0;
          if (mism && err_q != 3'd4) err_d = err_q + 3'd1;
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 3'd0);
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      // IDLE, DONE and any stray encoding all accept a new run
      default: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign a       = vec_q[1];
  assign b       = vec_q[0];
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;

`ifdef GATE_EXERCISER_FAIL_CAPTURE_EN
  logic [1:0] fail_vec_q, fail_vec_d;
  logic [1:0] fail_y_q, fail_y_d;

  always_comb begin
    fail_vec_d = fail_vec_q;
    fail_y_d   = fail_y_q;
    if (state_q != DRIVE && start) begin
      fail_vec_d = '0;
      fail_y_d   = '0;
    end else if (state_q == DRIVE && last && mism && err_q == 3'd0) begin
      fail_vec_d = vec_q;
      fail_y_d   = y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_vec_q <= '0;
      fail_y_q   <= '0;
    end else begin
      fail_vec_q <= fail_vec_d;
      fail_y_q   <= fail_y_d;
    end
  end

  assign fail_vec = fail_vec_q;
  assign fail_y   = fail_y_q;
`else
  assign fail_vec = '0;
  assign fail_y   = '0;
`endif
endmodule

// File: tb/tb_gate_exerciser.sv
// Randomized/directed bench for gate_exerciser at HOLD=4 and HOLD=1, with a bench-side gate emulation.
module tb_gate_exerciser;
`ifdef GATE_EXERCISER_FAIL_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            start_s [2];
  logic [1:0]      y_s     [2];
  logic            a_s     [2];
  logic            b_s     [2];
  logic            busy_s  [2];
  logic            done_s  [2];
  logic            pass_s  [2];
  logic [2:0]      err_s   [2];
  logic [1:0]      fv_s    [2];
  logic [1:0]      fy_s    [2];
  int              mode_s  [2];
  logic [3:0][1:0] rnd_s   [2];

  int errors = 0;
  int checks = 0;

  gate_exerciser #(.HOLD(4)) u_h4 (
    .clk(clk), .rst(rst), .start(start_s[0]), .y(y_s[0]),
    .a(a_s[0]), .b(b_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .err_cnt(err_s[0]), .fail_vec(fv_s[0]), .fail_y(fy_s[0])
  );

  gate_exerciser #(.HOLD(1)) u_h1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .y(y_s[1]),
    .a(a_s[1]), .b(b_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .err_cnt(err_s[1]), .fail_vec(fv_s[1]), .fail_y(fy_s[1])
  );

  // mode 0 good gate, 1 stuck at 00, 2 outputs swapped, 3 arbitrary per-vector table
  function automatic logic [1:0] gate_out(input int mode, input logic [3:0][1:0] rnd,
                                          input logic [1:0] v);
    logic nand_o, nor_o;
    nand_o = ~(v[1] & v[0]);
    nor_o  = ~(v[1] | v[0]);
    case (mode)
      0:       return {nor_o, nand_o};
      1:       return 2'b00;
      2:       return {nand_o, nor_o};
      default: return rnd[v];
    endcase
  endfunction

  function automatic logic [1:0] golden(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b11;
      2'b01:   return 2'b01;
      2'b10:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  assign y_s[0] = gate_out(mode_s[0], rnd_s[0], {a_s[0], b_s[0]});
  assign y_s[1] = gate_out(mode_s[1], rnd_s[1], {a_s[1], b_s[1]});

  function automatic int hold_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [11:0] outs(input int d);
    return {a_s[d], b_s[d], busy_s[d], done_s[d], pass_s[d], err_s[d], fv_s[d], fy_s[d]};
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int d, input int mode, input bit repulse);
    int h, ecnt;
    bit first;
    logic [1:0] yv, fvec, fyv;
    h = hold_of(d);
    ecnt = 0; first = 1'b1; fvec = '0; fyv = '0;
    mode_s[d] = mode;
    for (int v = 0; v < 4; v++) begin
      yv = gate_out(mode, rnd_s[d], 2'(v));
      if (yv != golden(2'(v))) begin
        ecnt++;
        if (first) begin fvec = 2'(v); fyv = yv; first = 1'b0; end
      end
    end
    @(negedge clk) start_s[d] = 1'b1;
    @(negedge clk) start_s[d] = 1'b0;
    for (int k = 0; k < 4 * h; k++) begin
      chk("vec", int'({a_s[d], b_s[d]}), k / h);
      chk("busy", int'(busy_s[d]), 1);
      chk("done_lo", int'(done_s[d]), 0);
      chk("pass_lo", int'(pass_s[d]), 0);
      if (k == 0) chk("cleared", int'({err_s[d], fv_s[d], fy_s[d]}), 0);
      start_s[d] = repulse && (k == 1);
      @(negedge clk);
    end
    start_s[d] = 1'b0;
    chk("fin_ctl", int'({busy_s[d], done_s[d], a_s[d], b_s[d]}), 4'b0100);
    chk("pass", int'(pass_s[d]), int'(ecnt == 0));
    chk("err_cnt", int'(err_s[d]), ecnt);
    chk("fail_vec", int'(fv_s[d]), CAP ? int'(fvec) : 0);
    chk("fail_y", int'(fy_s[d]), CAP ? int'(fyv) : 0);
    @(negedge clk);
    chk("done_hold", int'({done_s[d], err_s[d]}), int'({1'b1, 3'(ecnt)}));
  endtask

  // stuck-at-00 run on HOLD=4, reset asserted between edges during vector 10
  task automatic run_rst();
    mode_s[0] = 1;
    @(negedge clk) start_s[0] = 1'b1;
    @(negedge clk) start_s[0] = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    chk("mid_vec", int'({a_s[0], b_s[0]}), 2);
    chk("mid_err", int'(err_s[0]), 2);
    #2 rst = 1'b1;
    #1 chk("rst_async", int'(outs(0)), 0);
    @(negedge clk);
    chk("rst_hold", int'(outs(0)), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle", int'(outs(0)), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; mode_s[i] = 0; rnd_s[i] = '0;
    end
    @(negedge clk);
    chk("reset_h4", int'(outs(0)), 0);
    chk("reset_h1", int'(outs(1)), 0);
    rst = 1'b0;
    @(negedge clk);

    run(0, 0, 1'b0);
    run(0, 1, 1'b0);
    run(0, 2, 1'b0);
    run(0, 0, 1'b1);
    run(0, 2, 1'b1);
    run_rst();
    run(0, 0, 1'b0);
    run(1, 0, 1'b0);
    run(1, 1, 1'b1);
    run(1, 2, 1'b0);
    repeat (10) begin
      d = int'($urandom_range(0, 1));
      for (int v = 0; v < 4; v++) rnd_s[d][v] = 2'($urandom_range(0, 3));
      run(d, 3, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
